// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD up/down counter chain.
package stopwatch_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        MODE_DOWN0 = 2'b00,
        MODE_DOWN1 = 2'b01,
        MODE_UP    = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit with configurable modulus, inc/dec enables and load.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t value,
    output logic       is_max,
    output logic       is_zero
);

    localparam bcd_digit_t MAXV = 4'(MOD - 1);

    // Digit register: reset, then load, then increment or decrement with roll-over.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value == MAXV) ? '0 : value + 4'd1;
        end else if (dec) begin
            value <= (value == '0) ? MAXV : value - 4'd1;
        end
    end

    assign is_max  = (value == MAXV);
    assign is_zero = (value == '0);

endmodule

// File: rtl/bcd_updown_chain.sv
// Cascaded BCD up/down counter with load validation, terminal-count pulse
// and optional saturation at the bounds.
module bcd_updown_chain
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSD_MOD    = 10,
    parameter int WRAP       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [1:0]              s,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    zero,
    output logic                    load_err
);

    localparam bcd_digit_t MSD_LIM = 4'(MSD_MOD);

    logic [NUM_DIGITS-1:0] is_max;
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS:0]   borrow;
    logic [NUM_DIGITS-1:0] inc;
    logic [NUM_DIGITS-1:0] dec;
    logic                  load_ok;
    logic                  step_up;
    logic                  step_dn;
    logic                  term;
    logic                  freeze;
    logic                  load_acc;

    // Load validation: every digit must be decimal and the MSD below its modulus.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_MAX) load_ok = 1'b0;
        end
        if (load_val[4*NUM_DIGITS-1 -: 4] >= MSD_LIM) load_ok = 1'b0;
    end

    // Carry/borrow AND-chains and per-digit step enables; a load suppresses stepping.
    always_comb begin
        carry[0]  = 1'b1;
        borrow[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            carry[i+1]  = carry[i] & is_max[i];
            borrow[i+1] = borrow[i] & is_zero[i];
        end
        step_up  = en & ~load & (s == MODE_UP);
        step_dn  = en & ~load & ((s == MODE_DOWN0) | (s == MODE_DOWN1));
        term     = (step_up & carry[NUM_DIGITS]) | (step_dn & borrow[NUM_DIGITS]);
        freeze   = term & (WRAP == 0);
        load_acc = load & load_ok;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc[i] = step_up & carry[i] & ~freeze;
            dec[i] = step_dn & borrow[i] & ~freeze;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit #(
                .MOD((g == NUM_DIGITS - 1) ? MSD_MOD : 10)
            ) u_digit (
                .clk     (clk),
                .reset   (reset),
                .inc     (inc[g]),
                .dec     (dec[g]),
                .load    (load_acc),
                .load_val(load_val[4*g +: 4]),
                .value   (count[4*g +: 4]),
                .is_max  (is_max[g]),
                .is_zero (is_zero[g])
            );
        end
    endgenerate

    // Status pulses: terminal count on a step at the bound, error on a rejected load.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= term;
            load_err <= load & ~load_ok;
        end
    end

    assign zero = borrow[NUM_DIGITS];

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Directed self-checking bench: a wrapping and a saturating instance share stimulus.
module tb_bcd_updown_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  s;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count, count_sat;
    logic        tc, tc_sat, zero, zero_sat, load_err, load_err_sat;

    int checks = 0;
    int errors = 0;
    logic seen;

    always #5 clk = ~clk;

    bcd_updown_chain #(.NUM_DIGITS(4), .MSD_MOD(6), .WRAP(1)) dut (
        .clk(clk), .reset(reset), .en(en), .s(s), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .zero(zero), .load_err(load_err)
    );

    bcd_updown_chain #(.NUM_DIGITS(4), .MSD_MOD(6), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .s(s), .load(load), .load_val(load_val),
        .count(count_sat), .tc(tc_sat), .zero(zero_sat), .load_err(load_err_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; s = 2'b11; load = 1'b0; load_val = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_count", count, 32'h0);
        check("rst_tc", tc, 0);
        check("rst_load_err", load_err, 0);
        check("rst_zero", zero, 1);

        // Count up 10 ticks
        s = 2'b10; en = 1'b1; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | tc;
        end
        en = 1'b0;
        check("up10_count", count, 32'h0010);
        check("up10_tc_seen", seen, 0);
        check("up10_zero", zero, 0);

        // Ripple through a non-terminal carry
        do_load(16'h0599);
        en = 1'b1; tick(); en = 1'b0;
        check("ripple_up", count, 32'h0600);
        do_load(16'h1000);
        s = 2'b00; en = 1'b1; tick(); en = 1'b0;
        check("ripple_dn", count, 32'h0999);

        // Up wrap at MAX
        do_load(16'h5999);
        check("load_5999", count, 32'h5999);
        s = 2'b10; en = 1'b1; tick(); en = 1'b0;
        check("wrap_up_count", count, 32'h0000);
        check("wrap_up_tc", tc, 1);
        check("wrap_up_zero", zero, 1);
        check("sat_up_count", count_sat, 32'h5999);
        check("sat_up_tc", tc_sat, 1);
        tick();
        check("wrap_up_tc_end", tc, 0);

        // Down wrap at zero, then hold
        do_load(16'h0000);
        s = 2'b01; en = 1'b1; tick();
        check("wrap_dn_count", count, 32'h5999);
        check("wrap_dn_tc", tc, 1);
        s = 2'b11; seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | tc;
        end
        en = 1'b0;
        check("hold_count", count, 32'h5999);
        check("hold_tc_seen", seen, 0);

        // Rejected loads
        do_load(16'h0042);
        check("load_0042", count, 32'h0042);
        do_load(16'h6000);
        check("rej_msd_err", load_err, 1);
        check("rej_msd_count", count, 32'h0042);
        tick();
        check("rej_msd_err_end", load_err, 0);
        s = 2'b10; en = 1'b1;
        do_load(16'h12A4);
        check("rej_digit_err", load_err, 1);
        check("rej_digit_count", count, 32'h0042);
        en = 1'b0;
        tick();
        check("rej_digit_err_end", load_err, 0);

        // Load beats a step on the same edge
        en = 1'b1; s = 2'b10;
        do_load(16'h0123);
        en = 1'b0;
        check("load_vs_en", count, 32'h0123);
        check("load_vs_en_tc", tc, 0);

        // Reset overrides load and a terminal step
        do_load(16'h5999);
        reset = 1'b1; load = 1'b1; load_val = 16'h0777; en = 1'b1; s = 2'b10;
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        check("rst_load_count", count, 32'h0000);
        check("rst_load_tc", tc, 0);
        check("rst_load_zero", zero, 1);

        // Saturating down at zero
        do_load(16'h0001);
        s = 2'b00; en = 1'b1;
        tick();
        check("sat_t1_count", count_sat, 32'h0000);
        check("sat_t1_tc", tc_sat, 0);
        tick();
        check("sat_t2_count", count_sat, 32'h0000);
        check("sat_t2_tc", tc_sat, 1);
        check("wrap_t2_count", count, 32'h5999);
        tick();
        check("sat_t3_count", count_sat, 32'h0000);
        check("sat_t3_tc", tc_sat, 1);
        check("wrap_t3_count", count, 32'h5998);
        check("wrap_t3_tc", tc, 0);
        en = 1'b0;
        tick();
        check("sat_idle_tc", tc_sat, 0);
        check("sat_zero", zero_sat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_chain.md
BCD_UPDOWN_CHAIN -- requirements
Module: bcd_updown_chain

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 Parameter MSD_MOD, default 10, modulus of the most significant digit (2..10; e.g. 6 for the tens-of-seconds digit).
REQ-003 Parameter WRAP, default 1: 1 = wrap at the bound, 0 = saturate at the bound.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port en  in  1  count tick; one step per cycle while high.
REQ-007 Port s  in  2  mode: 00 = down, 01 = down, 10 = up, 11 = hold.
REQ-008 Port load  in  1  synchronous load strobe.
REQ-009 Port load_val  in  4*NUM_DIGITS  load value, BCD, digit 0 in bits [3:0].
REQ-010 Port count  out  4*NUM_DIGITS  registered BCD count, digit 0 least significant.
REQ-011 Port tc  out  1  registered terminal-count pulse.
REQ-012 Port zero  out  1  high when count equals all zeros; decoded combinationally from the count register.
REQ-013 Port load_err  out  1  registered pulse on a rejected load.

Function
REQ-014 Priority per edge: reset > load > count step > hold.
REQ-015 Bounds: digits below the MSD count 0..9; the MSD counts 0..MSD_MOD-1. MAX = the MSD at MSD_MOD-1 with all lower digits at 9.
REQ-016 Up step (s=10, en=1): digit 0 increments; digit i increments only when digits 0..i-1 are all at their maximum. A digit at its maximum that increments rolls to 0. Single-cycle ripple, no intermediate states visible.
REQ-017 Down step (s=0x, en=1): digit 0 decrements; digit i decrements only when digits 0..i-1 are all 0. A digit at 0 that decrements rolls to its maximum.
REQ-018 A step issued at the terminal value (MAX when up, zero when down): WRAP=1 moves the count to zero (up) or to MAX (down); WRAP=0 leaves the count unchanged.
REQ-019 tc is high for exactly one cycle, in the cycle after any edge on which a step was issued at the terminal value, regardless of WRAP. Otherwise tc is low.
REQ-020 s=11: en is ignored, the count holds, and tc stays low.
REQ-021 Load validation: reject the load if any digit of load_val is greater than 9, or if the MSD is greater than or equal to MSD_MOD.
REQ-022 Valid load: count = load_val on that edge; en is ignored on that edge; tc is not asserted.
REQ-023 Rejected load: the count is unchanged (no step that cycle either); load_err is high for one cycle after that edge.
REQ-024 Load is accepted in any mode, including s=11.
REQ-025 Mode changes take effect on the next edge; there is no pipeline, and count latency from a tick is 1 cycle.

Reset
REQ-026 On reset: count = 0, tc = 0, load_err = 0, and zero reads 1 from the following cycle.
REQ-027 Reset overrides a simultaneous load or en. Reset mid-count discards all state; there is no pending tc or load_err after reset.

Structure
REQ-028 Shared package stopwatch_pkg holds: the bcd_digit_t typedef (4-bit logic), the mode encodings (MODE_DOWN0 = 00, MODE_DOWN1 = 01, MODE_UP = 10, MODE_HOLD = 11), and the BCD_MAX = 9 constant.
REQ-029 One sub-module, bcd_digit: a single digit with modulus parameter, inc/dec enables, load, and max/zero flags. It is instantiated NUM_DIGITS times by generate, with MSD_MOD applied to the top instance.
REQ-030 Carry and borrow chains are combinational AND-chains of lower-digit max/zero flags. tc and load_err are the only other registers.

Verification (NUM_DIGITS=4, MSD_MOD=6, WRAP=1 unless stated)
REQ-031 Reset, then s=10 and en=1 for 10 cycles -> count = 16'h0010, tc never high, zero low.
REQ-032 Load 16'h5999, s=10, one tick -> count = 16'h0000, tc high for exactly the next cycle, zero = 1.
REQ-033 Load 16'h0000, s=01, one tick -> count = 16'h5999 and a tc pulse. Then s=11 with en=1 for 5 cycles -> count stays 16'h5999 and tc stays 0.
REQ-034 From count 16'h0042, load 16'h6000 -> load_err pulses once and count stays 16'h0042. Load 16'h12A4 -> same response.
REQ-035 Load 16'h0123 with en=1 and s=10 on the same edge -> count = 16'h0123. Reset together with load 16'h0777 -> count = 16'h0000.
REQ-036 WRAP=0: load 16'h0001, s=00, 3 ticks -> count 16'h0000 after tick 1 and held there; tc pulses after ticks 2 and 3 only.
